// File: rtl/mem_port_arb.sv
// Two-requester memory port arbiter: round-robin with sticky grants on stall,
// plus an in-order owner queue that steers each memory response to its requester.
module mem_port_arb #(
    parameter int  C_BUS_SZX = 5,
    parameter int  C_OUTST_X = 2,
    localparam int C_BUS_SZ  = 2**C_BUS_SZX
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    output logic                  ireqready_o,
    input  logic                  ireqvalid_i,
    input  logic [1:0]            ireqhpl_i,
    input  logic [C_BUS_SZ-1:0]   ireqaddr_i,
    output logic                  irspvalid_o,
    output logic                  irsprerr_o,
    output logic [C_BUS_SZ-1:0]   irspdata_o,

    output logic                  dreqready_o,
    input  logic                  dreqvalid_i,
    input  logic [1:0]            dreqhpl_i,
    input  logic [C_BUS_SZ-1:0]   dreqaddr_i,
    input  logic                  dreqwe_i,
    input  logic [C_BUS_SZ/8-1:0] dreqbe_i,
    input  logic [C_BUS_SZ-1:0]   dreqdata_i,
    output logic                  drspvalid_o,
    output logic                  drsprerr_o,
    output logic [C_BUS_SZ-1:0]   drspdata_o,

    input  logic                  mreqready_i,
    output logic                  mreqvalid_o,
    output logic [1:0]            mreqhpl_o,
    output logic [C_BUS_SZ-1:0]   mreqaddr_o,
    output logic                  mreqwe_o,
    output logic [C_BUS_SZ/8-1:0] mreqbe_o,
    output logic [C_BUS_SZ-1:0]   mreqdata_o,
    input  logic                  mrspvalid_i,
    input  logic                  mrsprerr_i,
    input  logic [C_BUS_SZ-1:0]   mrspdata_i,
    output logic                  mrspready_o,

    output logic [C_OUTST_X:0]    outst_o,
    output logic                  rsp_orphan_o
);

    localparam int                 DEPTH     = 2**C_OUTST_X;
    localparam logic [C_OUTST_X:0] DEPTH_CNT = (C_OUTST_X+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD_I = 2'd1;
    localparam logic [1:0] ST_HOLD_D = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  last_q;
    logic [C_OUTST_X:0]    outst_q;
    logic [C_OUTST_X:0]    outst_d;
    logic [C_OUTST_X-1:0]  wr_ptr_q;
    logic [C_OUTST_X-1:0]  rd_ptr_q;
    logic                  owner_q [DEPTH];
    logic                  orphan_q;

    logic                  full;
    logic                  empty;
    logic                  gnt_i;
    logic                  gnt_d;
    logic                  req_valid;
    logic                  push;
    logic                  pop;
    logic                  orphan_set;
    logic                  head_owner;

    assign full  = (outst_q == DEPTH_CNT);
    assign empty = (outst_q == '0);

    // Grant selection. Both valid in IDLE: the requester that did not win last.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (state_q)
            ST_HOLD_I: gnt_i = 1'b1;
            ST_HOLD_D: gnt_d = 1'b1;
            default: begin
                if (!full) begin
                    gnt_i = ireqvalid_i && (!dreqvalid_i || last_q == OWN_D);
                    gnt_d = dreqvalid_i && (!ireqvalid_i || last_q == OWN_I);
                end
            end
        endcase
    end

    assign req_valid   = (gnt_i || gnt_d) && !reset_i;
    assign push        = req_valid && mreqready_i;
    assign mreqvalid_o = req_valid;
    assign ireqready_o = push && gnt_i;
    assign dreqready_o = push && gnt_d;

    assign mreqhpl_o  = gnt_d ? dreqhpl_i  : ireqhpl_i;
    assign mreqaddr_o = gnt_d ? dreqaddr_i : ireqaddr_i;
    assign mreqwe_o   = gnt_d ? dreqwe_i   : 1'b0;
    assign mreqbe_o   = gnt_d ? dreqbe_i   : '1;
    assign mreqdata_o = gnt_d ? dreqdata_i : '0;

    // Responses always route by the head as it stood before any same-cycle push.
    assign head_owner  = owner_q[rd_ptr_q];
    assign pop         = mrspvalid_i && !empty && !reset_i;
    assign orphan_set  = mrspvalid_i && empty && !reset_i;
    assign mrspready_o = mrspvalid_i && !reset_i;

    assign irspvalid_o = pop && (head_owner == OWN_I);
    assign drspvalid_o = pop && (head_owner == OWN_D);
    assign irsprerr_o  = mrsprerr_i;
    assign drsprerr_o  = mrsprerr_i;
    assign irspdata_o  = mrspdata_i;
    assign drspdata_o  = mrspdata_i;

    assign outst_o      = outst_q;
    assign rsp_orphan_o = orphan_q && !reset_i;

    always_comb begin
        state_d = state_q;
        if (req_valid) begin
            if (mreqready_i) begin
                state_d = ST_IDLE;
            end else begin
                state_d = gnt_d ? ST_HOLD_D : ST_HOLD_I;
            end
        end
    end

    assign outst_d = outst_q + (C_OUTST_X+1)'(push) - (C_OUTST_X+1)'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            last_q   <= OWN_D;
            outst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            if (push) begin
                last_q   <= gnt_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (orphan_set) begin
                orphan_q <= 1'b1;
            end
        end
    end

    // NOTE: the owner storage has no reset; entries are only read between matching pointers, which are reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            owner_q[wr_ptr_q] <= gnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (default 32-bit bus, 4-deep owner queue).
module tb_mem_port_arb;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ireqready_o, ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspvalid_o, irsprerr_o;
    logic [31:0] irspdata_o;
    logic        dreqready_o, dreqvalid_i;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic        dreqwe_i;
    logic [3:0]  dreqbe_i;
    logic [31:0] dreqdata_i;
    logic        drspvalid_o, drsprerr_o;
    logic [31:0] drspdata_o;
    logic        mreqready_i, mreqvalid_o;
    logic [1:0]  mreqhpl_o;
    logic [31:0] mreqaddr_o;
    logic        mreqwe_o;
    logic [3:0]  mreqbe_o;
    logic [31:0] mreqdata_o;
    logic        mrspvalid_i, mrsprerr_i;
    logic [31:0] mrspdata_i;
    logic        mrspready_o;
    logic [2:0]  outst_o;
    logic        rsp_orphan_o;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    mem_port_arb dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
        .ireqaddr_i(ireqaddr_i), .irspvalid_o(irspvalid_o), .irsprerr_o(irsprerr_o),
        .irspdata_o(irspdata_o),
        .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqhpl_i(dreqhpl_i),
        .dreqaddr_i(dreqaddr_i), .dreqwe_i(dreqwe_i), .dreqbe_i(dreqbe_i),
        .dreqdata_i(dreqdata_i), .drspvalid_o(drspvalid_o), .drsprerr_o(drsprerr_o),
        .drspdata_o(drspdata_o),
        .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqhpl_o(mreqhpl_o),
        .mreqaddr_o(mreqaddr_o), .mreqwe_o(mreqwe_o), .mreqbe_o(mreqbe_o),
        .mreqdata_o(mreqdata_o), .mrspvalid_i(mrspvalid_i), .mrsprerr_i(mrsprerr_i),
        .mrspdata_i(mrspdata_i), .mrspready_o(mrspready_o),
        .outst_o(outst_o), .rsp_orphan_o(rsp_orphan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset_i = 1'b1;
        ireqvalid_i = 0; ireqhpl_i = 2'd3; ireqaddr_i = 32'h100;
        dreqvalid_i = 0; dreqhpl_i = 2'd1; dreqaddr_i = 32'h200;
        dreqwe_i = 0; dreqbe_i = 4'h0; dreqdata_i = 32'h0;
        mreqready_i = 1; mrspvalid_i = 0; mrsprerr_i = 0; mrspdata_i = 32'h0;
        tick();

        // Everything handshaking is forced low while reset is held.
        ireqvalid_i = 1; dreqvalid_i = 1; mrspvalid_i = 1;
        settle();
        check("rst_mreqvalid", mreqvalid_o, 0);
        check("rst_ireqready", ireqready_o, 0);
        check("rst_dreqready", dreqready_o, 0);
        check("rst_irspvalid", irspvalid_o, 0);
        check("rst_drspvalid", drspvalid_o, 0);
        check("rst_mrspready", mrspready_o, 0);
        check("rst_orphan", rsp_orphan_o, 0);
        tick();
        reset_i = 0; ireqvalid_i = 0; dreqvalid_i = 0; mrspvalid_i = 0;
        settle();
        check("post_rst_outst", outst_o, 0);
        check("post_rst_orphan", rsp_orphan_o, 0);
        check("post_rst_mreqvalid", mreqvalid_o, 0);

        // Both requesters always valid, response one cycle after each accept.
        ireqvalid_i = 1; dreqvalid_i = 1;
        for (int k = 0; k < 6; k++) begin
            mrspvalid_i = (k > 0);
            mrspdata_i  = 32'hA0 + 32'(k) - 32'd1;
            settle();
            check($sformatf("rr_ireqready_%0d", k), ireqready_o, (k % 2) == 0);
            check($sformatf("rr_dreqready_%0d", k), dreqready_o, (k % 2) == 1);
            check($sformatf("rr_addr_%0d", k), mreqaddr_o, (k % 2) == 0 ? 32'h100 : 32'h200);
            check($sformatf("rr_outst_%0d", k), outst_o, (k > 0) ? 1 : 0);
            if (k > 0) begin
                check($sformatf("rr_irsp_%0d", k), irspvalid_o, ((k - 1) % 2) == 0);
                check($sformatf("rr_drsp_%0d", k), drspvalid_o, ((k - 1) % 2) == 1);
                check($sformatf("rr_rdata_%0d", k), irspvalid_o ? irspdata_o : drspdata_o,
                      32'hA0 + 32'(k) - 32'd1);
            end
            tick();
        end
        ireqvalid_i = 0; dreqvalid_i = 0; mrspvalid_i = 1; mrspdata_i = 32'hA5;
        settle();
        check("rr_last_drsp", drspvalid_o, 1);
        check("rr_last_irsp", irspvalid_o, 0);
        tick();
        mrspvalid_i = 0;
        settle();
        check("rr_drained", outst_o, 0);

        // Sticky ifetch grant through a 3-cycle stall; data request arrives mid-stall.
        ireqvalid_i = 1; ireqaddr_i = 32'h300; mreqready_i = 0;
        settle();
        check("hold_c1_valid", mreqvalid_o, 1);
        check("hold_c1_addr", mreqaddr_o, 32'h300);
        check("hold_c1_iready", ireqready_o, 0);
        tick();
        dreqvalid_i = 1; dreqaddr_i = 32'h400; dreqwe_i = 1; dreqbe_i = 4'h3; dreqdata_i = 32'hDEAD;
        for (int c = 2; c <= 3; c++) begin
            settle();
            check($sformatf("hold_c%0d_addr", c), mreqaddr_o, 32'h300);
            check($sformatf("hold_c%0d_dready", c), dreqready_o, 0);
            check($sformatf("hold_c%0d_iready", c), ireqready_o, 0);
            tick();
        end
        mreqready_i = 1;
        settle();
        check("hold_c4_iready", ireqready_o, 1);
        check("hold_c4_addr", mreqaddr_o, 32'h300);
        check("hold_c4_we", mreqwe_o, 0);
        check("hold_c4_be", mreqbe_o, 4'hF);
        check("hold_c4_hpl", mreqhpl_o, 2'd3);
        tick();
        ireqvalid_i = 0;
        settle();
        check("hold_d_ready", dreqready_o, 1);
        check("hold_d_addr", mreqaddr_o, 32'h400);
        check("hold_d_we", mreqwe_o, 1);
        check("hold_d_be", mreqbe_o, 4'h3);
        check("hold_d_data", mreqdata_o, 32'hDEAD);
        check("hold_d_hpl", mreqhpl_o, 2'd1);
        tick();
        dreqvalid_i = 0; dreqwe_i = 0; dreqbe_i = 4'hF;
        mrspvalid_i = 1;
        settle();
        check("hold_rsp1_i", irspvalid_o, 1);
        tick();
        settle();
        check("hold_rsp2_d", drspvalid_o, 1);
        tick();
        mrspvalid_i = 0;
        settle();
        check("hold_drained", outst_o, 0);

        // Fill the owner queue; a same-cycle response does not unblock the grant.
        ireqvalid_i = 1; ireqaddr_i = 32'h500;
        for (int n = 0; n < 4; n++) begin
            settle();
            check($sformatf("fill_iready_%0d", n), ireqready_o, 1);
            tick();
        end
        mrspvalid_i = 1;
        settle();
        check("full_outst", outst_o, 4);
        check("full_mreqvalid", mreqvalid_o, 0);
        check("full_iready", ireqready_o, 0);
        check("full_rsp_i", irspvalid_o, 1);
        tick();
        mrspvalid_i = 0;
        settle();
        check("unfull_outst", outst_o, 3);
        check("unfull_mreqvalid", mreqvalid_o, 1);
        ireqvalid_i = 0;
        mrspvalid_i = 1;
        tick();
        tick();
        tick();
        mrspvalid_i = 0;
        settle();
        check("full_drained", outst_o, 0);

        // Interleaved I,D,D,I accepts, then routed in-order responses.
        ireqvalid_i = 1; tick();
        ireqvalid_i = 0; dreqvalid_i = 1; tick();
        tick();
        dreqvalid_i = 0; ireqvalid_i = 1; tick();
        ireqvalid_i = 0;
        settle();
        check("il_outst", outst_o, 4);
        mrspvalid_i = 1; mrspdata_i = 32'h11; mrsprerr_i = 0;
        settle();
        check("il_r1_ivalid", irspvalid_o, 1);
        check("il_r1_dvalid", drspvalid_o, 0);
        check("il_r1_data", irspdata_o, 32'h11);
        tick();
        mrspdata_i = 32'h22;
        settle();
        check("il_r2_dvalid", drspvalid_o, 1);
        check("il_r2_data", drspdata_o, 32'h22);
        check("il_r2_err", drsprerr_o, 0);
        tick();
        mrspdata_i = 32'h33; mrsprerr_i = 1;
        settle();
        check("il_r3_dvalid", drspvalid_o, 1);
        check("il_r3_data", drspdata_o, 32'h33);
        check("il_r3_err", drsprerr_o, 1);
        tick();
        mrspdata_i = 32'h44; mrsprerr_i = 0;
        settle();
        check("il_r4_ivalid", irspvalid_o, 1);
        check("il_r4_dvalid", drspvalid_o, 0);
        check("il_r4_data", irspdata_o, 32'h44);
        tick();
        mrspvalid_i = 0;

        // Simultaneous accept and response at outst=2 (queue holds D then I).
        dreqvalid_i = 1; tick();
        dreqvalid_i = 0; ireqvalid_i = 1; tick();
        mrspvalid_i = 1;
        settle();
        check("sim_pre_outst", outst_o, 2);
        check("sim_iready", ireqready_o, 1);
        check("sim_drsp", drspvalid_o, 1);
        check("sim_irsp", irspvalid_o, 0);
        tick();
        ireqvalid_i = 0;
        settle();
        check("sim_post_outst", outst_o, 2);
        check("sim_next_irsp", irspvalid_o, 1);
        tick();
        tick();
        mrspvalid_i = 0;
        settle();
        check("sim_drained", outst_o, 0);

        // Reset with 3 outstanding; a late response becomes an orphan.
        ireqvalid_i = 1;
        tick(); tick(); tick();
        settle();
        check("rst2_pre_outst", outst_o, 3);
        reset_i = 1; dreqvalid_i = 1;
        settle();
        check("rst2_mreqvalid", mreqvalid_o, 0);
        check("rst2_iready", ireqready_o, 0);
        check("rst2_dready", dreqready_o, 0);
        check("rst2_orphan", rsp_orphan_o, 0);
        tick();
        reset_i = 0; ireqvalid_i = 0; dreqvalid_i = 0;
        settle();
        check("rst2_outst", outst_o, 0);
        mrspvalid_i = 1;
        settle();
        check("orph_irsp", irspvalid_o, 0);
        check("orph_drsp", drspvalid_o, 0);
        tick();
        mrspvalid_i = 0;
        settle();
        check("orph_set", rsp_orphan_o, 1);
        check("orph_outst", outst_o, 0);
        tick();
        settle();
        check("orph_sticky", rsp_orphan_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter and response router that shares one memory bus port between the instruction prefetch unit (ifetch side) and the load/store unit (data side). It multiplexes requests onto the shared port using round-robin arbitration with sticky grants, and records the owner of every accepted request in an in-order owner queue. Each in-order memory response is steered back to its owner. The block sits between the core's fetch/LSU stages and the memory/cache interconnect.

## Interface
- C_BUS_SZX, 5, bus width base-2 exponent
- C_BUS_SZ, 2**C_BUS_SZX, bus width in bits (derived, not overridden)
- C_OUTST_X, 2, log2 of the maximum number of outstanding requests (owner-queue depth)

- clk_i  in  1  clock; all state changes on its rising edge
- reset_i  in  1  synchronous, active-high reset
- ireqready_o  out  1  ifetch request accepted this cycle
- ireqvalid_i  in  1  ifetch request valid
- ireqhpl_i  in  2  ifetch HART privilege level
- ireqaddr_i  in  C_BUS_SZ  ifetch address
- irspvalid_o  out  1  ifetch response valid; requester always accepts
- irsprerr_o  out  1  ifetch response error
- irspdata_o  out  C_BUS_SZ  ifetch response data
- dreqready_o  out  1  data request accepted this cycle
- dreqvalid_i  in  1  data request valid
- dreqhpl_i  in  2  data privilege level
- dreqaddr_i  in  C_BUS_SZ  data address
- dreqwe_i  in  1  write enable
- dreqbe_i  in  C_BUS_SZ/8  byte enables
- dreqdata_i  in  C_BUS_SZ  write data
- drspvalid_o  out  1  data response valid; requester always accepts
- drsprerr_o  out  1  data response error
- drspdata_o  out  C_BUS_SZ  data response (read data; don't-care for writes)
- mreqready_i  in  1  memory accepts request
- mreqvalid_o  out  1  memory request valid
- mreqhpl_o / mreqaddr_o / mreqwe_o / mreqbe_o / mreqdata_o  out  2 / C_BUS_SZ / 1 / C_BUS_SZ/8 / C_BUS_SZ  muxed request fields; mreqwe_o=0 and mreqbe_o=all-ones for ifetch
- mrspvalid_i  in  1  memory response valid, in request order, exactly one per request (writes included)
- mrsprerr_i  in  1  response error
- mrspdata_i  in  C_BUS_SZ  response data
- mrspready_o  out  1  equals mrspvalid_i; always ready
- outst_o  out  C_OUTST_X+1  outstanding-request count
- rsp_orphan_o  out  1  sticky; set by a response arriving with an empty owner queue

## Operation
- States: IDLE, HOLD_I, HOLD_D. The round-robin pointer last_q records the most recently accepted owner (0 = I, 1 = D).
- full = (outst == 2**C_OUTST_X).
- IDLE, not full:
  - Exactly one requester valid: grant that requester.
  - Both valid: grant the requester that is not last_q.
  - Neither valid: no grant; mreqvalid_o=0.
- IDLE, full: no grant, mreqvalid_o=0, both readies 0.
- Grant presented and mreqready_i=1: the request is accepted. The owner's ready goes high, the owner bit is pushed to the queue, outst increments, last_q is updated, and the state stays IDLE.
- Grant presented and mreqready_i=0: go to HOLD_x. The grant and mreqvalid_o stay fixed, and the other requester is ignored, until acceptance; then return to IDLE.
- A requester keeps its valid and fields stable until ready. Fields are muxed combinationally from the granted requester.
- Response routing, with mrspvalid_i=1:
  - Queue non-empty: the head owner's rspvalid goes high, and err/data pass through combinationally. Pop the head and decrement outst.
  - Queue empty: drop the response and set rsp_orphan_o.
- Accept and response in the same cycle: push and pop both occur and outst is unchanged. The response always routes by the pre-push head.
- The full check uses the registered count. A response in the same cycle does not unblock a new grant.
- Count arithmetic is C_OUTST_X+1 bits wide. Queue pointers are C_OUTST_X bits and wrap modulo depth.

## Timing
- Request path is zero latency: ready and mreqvalid_o are combinational from the inputs, state, and count.
- Response path is zero latency: mrsp to irsp/drsp is combinational.
- While reset_i=1, every valid/ready output and rsp_orphan_o are forced to 0.
- At the first clock after reset: state IDLE, last_q=1 (so ifetch wins the first tie), outst=0, queue empty, rsp_orphan_o=0.
- Reset mid-operation discards outstanding ownership. Responses to pre-reset requests arriving afterwards count as orphans.
- Throughput: one acceptance per cycle.

## Test plan
- Both requesters valid every cycle, mreqready_i=1, and a response returned 1 cycle after each acceptance:
  - Grants alternate I,D,I,D starting with I.
  - Each response is delivered to the matching owner.
  - outst stays at or below 1.
- Only ifetch valid, and data goes valid while ifetch is in HOLD_I with mreqready_i=0 for 3 cycles:
  - mreqaddr_o stays at the ifetch address throughout.
  - The ifetch request is accepted on cycle 4.
  - The data request is granted next.
- Accept 4 requests with no response (C_OUTST_X=2):
  - outst=4 and mreqvalid_o=0.
  - A response arriving in that cycle does not unblock the grant until the following cycle.
- Interleaved I,D,D,I accepts, then 4 in-order responses with data 0x11,0x22,0x33,0x44 and rerr on the 3rd:
  - irsp receives 0x11 then 0x44.
  - drsp receives 0x22, then 0x33 with drsprerr_o=1.
- Accept and response in the same cycle at outst=2: outst stays 2 and the response goes to the old head owner.
- Assert reset_i with outst=3, then deliver a response afterwards:
  - All outputs are 0 during reset.
  - After reset, outst=0, the response is dropped, and rsp_orphan_o=1 (sticky).
